// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronises NUM_IRQ peripheral requests, latches edges or
// tracks levels per source, masks them, counts edge events and drives a single CPU irq line.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                irq
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned POP_W     = 5;
    localparam int unsigned CNT_SUM_W = DATA_W + 1;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_RAW     = 3'd5;
    localparam logic [2:0] ADDR_COUNT   = 3'd6;

    logic [NUM_IRQ-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0]   prev_q;
    logic [NUM_IRQ-1:0]   pending_q;
    logic [NUM_IRQ-1:0]   mask_q;
    logic [NUM_IRQ-1:0]   mode_q;
    logic [DATA_W-1:0]    count_q;

    logic                 wr_en;
    logic                 pending_wr;
    logic                 mask_wr;
    logic                 mode_wr;
    logic                 count_wr;
    logic [NUM_IRQ-1:0]   sync_out;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   active;
    logic [NUM_IRQ-1:0]   pending_next;
    logic [IDX_W-1:0]     vec_idx;
    logic [POP_W-1:0]     event_cnt;
    logic [CNT_SUM_W-1:0] count_sum;
    logic [DATA_W-1:0]    count_next;
    logic [DATA_W-1:0]    rd_mux;

    // Register write decode
    assign wr_en      = chipselect & ~write_n;
    assign pending_wr = wr_en && (address == ADDR_PENDING);
    assign mask_wr    = wr_en && (address == ADDR_MASK);
    assign mode_wr    = wr_en && (address == ADDR_MODE);
    assign count_wr   = wr_en && (address == ADDR_COUNT);

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign active   = pending_q & mask_q;

    // Per-source pending update; a mode change discards whatever the bit held
    always_comb begin
        pending_next = pending_q;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (mode_wr && (writedata[i] != mode_q[i])) begin
                pending_next[i] = 1'b0;
            end else if (!mode_q[i]) begin
                pending_next[i] = sync_out[i];
            end else if (rise[i]) begin
                pending_next[i] = 1'b1;
            end else if (pending_wr && writedata[i]) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    // Lowest active index wins: scan downward so the last hit is the smallest
    always_comb begin
        vec_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = IDX_W'(i);
            end
        end
    end

    // Saturating edge-event counter; events are counted regardless of mask
    always_comb begin
        event_cnt = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            event_cnt = event_cnt + POP_W'(rise[i] & mode_q[i]);
        end
        count_sum  = CNT_SUM_W'(count_q) + CNT_SUM_W'(event_cnt);
        count_next = count_sum[DATA_W] ? {DATA_W{1'b1}} : count_sum[DATA_W-1:0];
    end

    // Read mux, registered below for one-cycle read latency
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING: rd_mux = DATA_W'(pending_q);
            ADDR_MASK:    rd_mux = DATA_W'(mask_q);
            ADDR_MODE:    rd_mux = DATA_W'(mode_q);
            ADDR_ACTIVE:  rd_mux = DATA_W'(active);
            ADDR_VECTOR:  rd_mux = {|active, 11'b0, vec_idx};
            ADDR_RAW:     rd_mux = DATA_W'(sync_out);
            ADDR_COUNT:   rd_mux = count_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            count_q   <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q    <= sync_out;
            pending_q <= pending_next;
            if (mask_wr) begin
                mask_q <= writedata[NUM_IRQ-1:0];
            end
            if (mode_wr) begin
                mode_q <= writedata[NUM_IRQ-1:0];
            end
            count_q  <= count_wr ? '0 : count_next;
            readdata <= rd_mux;
            irq      <= |active;
        end
    end

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed self-checking bench for irq_aggregator (NUM_IRQ=8, SYNC_STAGES=2).
module tb_irq_aggregator;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int vectors;
    int errors;

    irq_aggregator #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick(1);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), rd);
            vectors++;
            if (rd !== 16'h0000) begin errors++; $display("FAIL reset_addr%0d: got %h expected 0000", a, rd); end
        end
    endtask

    task automatic test_regs();
        logic [15:0] rd;
        do_write(3'd1, 16'hFFFF);
        do_read(3'd1, rd);
        vectors++;
        if (rd !== 16'h00FF) begin errors++; $display("FAIL mask_width: got %h expected 00ff", rd); end
        do_write(3'd7, 16'hFFFF);
        do_read(3'd7, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL addr7: got %h expected 0000", rd); end
        do_write(3'd2, 16'hFF00);
        do_read(3'd2, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL mode_width: got %h expected 0000", rd); end
        do_write(3'd1, 16'h0000);
    endtask

    task automatic test_edge_latency();
        logic [15:0] rd;
        do_write(3'd2, 16'h0001);
        do_write(3'd1, 16'h0001);
        irq_in = 8'h01;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL edge_lat_k2: got %b expected 0", irq); end
        tick(1);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL edge_lat_k3: got %b expected 1", irq); end
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL edge_pending: got %h expected 0001", rd); end
        do_read(3'd4, rd);
        vectors++;
        if (rd !== 16'h8000) begin errors++; $display("FAIL edge_vector: got %h expected 8000", rd); end
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL edge_count: got %h expected 0001", rd); end
        do_write(3'd0, 16'h0001);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_same_edge: got %b expected 1", irq); end
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL w1c_pending: got %h expected 0000", rd); end
    endtask

    task automatic test_level();
        logic [15:0] rd;
        do_write(3'd2, 16'h0000);
        do_write(3'd1, 16'h0008);
        irq_in = 8'h08;
        tick(4);
        do_read(3'd4, rd);
        vectors++;
        if (rd !== 16'h8003) begin errors++; $display("FAIL level_vector: got %h expected 8003", rd); end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL level_irq: got %b expected 1", irq); end
        do_write(3'd0, 16'h0008);
        tick(1);
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0008) begin errors++; $display("FAIL level_w1c: got %h expected 0008", rd); end
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL level_w1c_irq: got %b expected 1", irq); end
        irq_in = 8'h00;
        tick(3);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL level_drop_k2: got %b expected 1", irq); end
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL level_drop_k3: got %b expected 0", irq); end
    endtask

    task automatic test_priority_mask();
        logic [15:0] rd;
        irq_in = 8'h24;
        do_write(3'd1, 16'h0024);
        tick(3);
        do_read(3'd4, rd);
        vectors++;
        if (rd !== 16'h8002) begin errors++; $display("FAIL prio_2_5: got %h expected 8002", rd); end
        do_write(3'd1, 16'h0020);
        do_read(3'd4, rd);
        vectors++;
        if (rd !== 16'h8005) begin errors++; $display("FAIL prio_5: got %h expected 8005", rd); end
        do_write(3'd1, 16'h0000);
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq); end
        do_read(3'd3, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL masked_active: got %h expected 0000", rd); end
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0024) begin errors++; $display("FAIL masked_pending: got %h expected 0024", rd); end
        do_read(3'd5, rd);
        vectors++;
        if (rd !== 16'h0024) begin errors++; $display("FAIL raw: got %h expected 0024", rd); end
        do_read(3'd4, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL vector_none: got %h expected 0000", rd); end
        irq_in = 8'h00;
        tick(4);
    endtask

    task automatic test_rise_vs_w1c();
        logic [15:0] rd;
        do_write(3'd2, 16'h0002);
        do_write(3'd1, 16'h0002);
        irq_in = 8'h02;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        do_write(3'd0, 16'h0002);
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL rise_wins: got %h expected 0002", rd); end
        do_write(3'd0, 16'h0002);
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL w1c_edge1: got %h expected 0000", rd); end
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL count_two: got %h expected 0002", rd); end
        for (int p = 0; p < 2; p++) begin
            irq_in = 8'h02;
            tick(1);
            irq_in = 8'h00;
            tick(1);
        end
        tick(3);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0004) begin errors++; $display("FAIL two_rises_count: got %h expected 0004", rd); end
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL two_rises_pend: got %h expected 0002", rd); end
        do_write(3'd0, 16'h0002);
    endtask

    task automatic test_count();
        logic [15:0] rd;
        do_write(3'd2, 16'h00FF);
        do_write(3'd6, 16'h1234);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL count_clear0: got %h expected 0000", rd); end
        for (int p = 0; p < 100; p++) begin
            irq_in = 8'hFF;
            tick(1);
            irq_in = 8'h00;
            tick(1);
        end
        tick(3);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0320) begin errors++; $display("FAIL count_800: got %h expected 0320", rd); end
        for (int p = 0; p < 8650; p++) begin
            irq_in = 8'hFF;
            tick(1);
            irq_in = 8'h00;
            tick(1);
        end
        tick(3);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'hFFFF) begin errors++; $display("FAIL count_sat: got %h expected ffff", rd); end
        do_write(3'd6, 16'h0000);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL count_clear: got %h expected 0000", rd); end
        irq_in = 8'hFF;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        do_write(3'd6, 16'h0000);
        tick(2);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL clear_wins: got %h expected 0000", rd); end
        irq_in = 8'hFF;
        tick(1);
        irq_in = 8'h00;
        tick(4);
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0008) begin errors++; $display("FAIL count_after_clear: got %h expected 0008", rd); end
    endtask

    task automatic test_async_reset();
        logic [15:0] rd;
        do_write(3'd2, 16'h0000);
        do_write(3'd1, 16'h0001);
        address = 3'd1;
        irq_in  = 8'h01;
        tick(4);
        vectors++;
        if (irq !== 1'b1 || readdata !== 16'h0001) begin
            errors++; $display("FAIL pre_reset: got irq=%b rd=%h expected irq=1 rd=0001", irq, readdata);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (irq !== 1'b0 || readdata !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got irq=%b rd=%h expected irq=0 rd=0000", irq, readdata);
        end
        irq_in = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        do_read(3'd1, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected 0000", rd); end
        do_read(3'd6, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", rd); end
        do_read(3'd0, rd);
        vectors++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL reset_pending: got %h expected 0000", rd); end
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_regs();
        test_edge_latency();
        test_level();
        test_priority_mask();
        test_rise_vs_w1c();
        test_count();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
